// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART blocks
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;
  localparam int CLKS_PER_BIT_MIN = 1;
  localparam int CLKS_PER_BIT_MAX = 65535;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - valid/ready word feed into the UART transmitter
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with end-of-bit strobe
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST);

  // Wrapping on bit_end doubles as the clear on every state change.
  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter: start, data LSB first, optional parity, 1-2 stops
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_param_if.slave  tx,
  output logic            tx_out,
  output logic            tx_busy,
  output logic            tx_done
);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX ||
      DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : gen_bad_params
    $error("uart_tx_param: parameter out of range");
  end

  localparam int IDX_W = $clog2(DATA_BITS_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS);
  localparam bit   HAS_PARITY = (PARITY_EN != 0);
  localparam logic PAR_MODE   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 parity_q, parity_d;
  logic                 tx_out_q, tx_out_d;
  logic                 done_q, done_d;
  logic                 ready;
  logic                 bit_end;

  assign ready       = (state_q == IDLE) && !rst;
  assign tx.tx_ready = ready;
  assign tx_out      = tx_out_q;
  assign tx_busy     = (state_q != IDLE);
  assign tx_done     = done_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    tx_out_d = tx_out_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        if (tx.tx_valid && ready) begin
          state_d  = START;
          shreg_d  = tx.tx_data;
          parity_d = parity_of(DATA_BITS_MAX'(tx.tx_data), PAR_MODE);
          idx_d    = '0;
          tx_out_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          tx_out_d = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          idx_d    = IDX_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q < LAST_DATA) begin
            tx_out_d = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            idx_d    = idx_q + IDX_W'(1);
          end else if (HAS_PARITY) begin
            state_d  = PARITY;
            tx_out_d = parity_q;
          end else begin
            state_d  = STOP;
            tx_out_d = 1'b1;
            idx_d    = IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          tx_out_d = 1'b1;
          idx_d    = IDX_W'(1);
        end
      end
      STOP: begin
        // idx counts stop bits already started; the last one ends the frame.
        if (bit_end) begin
          if (idx_q < LAST_STOP) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - randomized and directed bench over several UART configurations
module tb_uart_tx_param;

  localparam int NCFG = 6;

  function automatic int cfg_cpb(int g);
    case (g)
      4:       return 1;
      5:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_db(int g);
    case (g)
      3:       return 7;
      5:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_par(int g);
    return (g == 1 || g == 2 || g == 5) ? 1 : 0;
  endfunction

  function automatic int cfg_odd(int g);
    return (g == 2 || g == 5) ? 1 : 0;
  endfunction

  function automatic int cfg_stop(int g);
    return (g == 3 || g == 5) ? 2 : 1;
  endfunction

  logic            clk;
  logic            rst;
  logic [NCFG-1:0] valid_w, ready_w, out_w, busy_w, done_w;
  logic [8:0]      data_w [NCFG];

  int n_checks;
  int n_fails;
  bit exp_bits[$];
  bit obs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : gen_dut
    localparam int D = cfg_db(g);
    uart_tx_param_if #(.DATA_BITS(D)) bus ();
    assign bus.tx_valid = valid_w[g];
    assign bus.tx_data  = data_w[g][D-1:0];
    assign ready_w[g]   = bus.tx_ready;
    uart_tx_param #(
      .CLKS_PER_BIT (cfg_cpb(g)),
      .DATA_BITS    (D),
      .PARITY_EN    (cfg_par(g)),
      .PARITY_ODD   (cfg_odd(g)),
      .STOP_BITS    (cfg_stop(g))
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx      (bus),
      .tx_out  (out_w[g]),
      .tx_busy (busy_w[g]),
      .tx_done (done_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: one entry per serial bit, built from the frame rules.
  task automatic build_frame(input int g, input logic [8:0] w);
    int ones;
    ones = 0;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < cfg_db(g); i++) begin
      exp_bits.push_back(bit'(w[i]));
      ones += int'(w[i]);
    end
    if (cfg_par(g) != 0) begin
      if (cfg_odd(g) != 0) exp_bits.push_back(bit'((ones % 2) == 0));
      else                 exp_bits.push_back(bit'((ones % 2) == 1));
    end
    for (int s = 0; s < cfg_stop(g); s++) exp_bits.push_back(1'b1);
  endtask

  function automatic logic [31:0] obs_slice(int lo, int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = obs[lo + i];
    return v;
  endfunction

  // Entered at a negedge with the DUT idle; leaves at the negedge of the tx_done cycle.
  task automatic send(input int g, input logic [8:0] w, input bit chain, input string tag);
    int c;
    int len;
    build_frame(g, w);
    c   = cfg_cpb(g);
    len = exp_bits.size() * c;
    valid_w[g] = 1'b1;
    data_w[g]  = w;
    check({tag, "_ready_idle"}, 32'(ready_w[g]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid_w[g] = chain;
    obs = {};
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      data_w[g] = 9'($urandom);
      check($sformatf("%s_out%0d", tag, k), 32'(out_w[g]), 32'(exp_bits[k / c]));
      check($sformatf("%s_busy%0d", tag, k), 32'(busy_w[g]), 32'd1);
      check($sformatf("%s_done%0d", tag, k), 32'(done_w[g]), 32'd0);
      check($sformatf("%s_rdy%0d", tag, k), 32'(ready_w[g]), 32'd0);
      if (k % c == 0) obs.push_back(bit'(out_w[g]));
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_w[g]), 32'd1);
    check({tag, "_busy_end"}, 32'(busy_w[g]), 32'd0);
    check({tag, "_out_gap"}, 32'(out_w[g]), 32'd1);
    check({tag, "_ready_done"}, 32'(ready_w[g]), 32'd1);
  endtask

  task automatic idle(input int g, input int n, input string tag);
    valid_w[g] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_idle_done%0d", tag, i), 32'(done_w[g]), 32'd0);
      check($sformatf("%s_idle_out%0d", tag, i), 32'(out_w[g]), 32'd1);
      check($sformatf("%s_idle_busy%0d", tag, i), 32'(busy_w[g]), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w;
    bit         chain;
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    valid_w  = '1;
    for (int g = 0; g < NCFG; g++) data_w[g] = 9'h0A5;

    // Reset: valid is held high and must be ignored.
    repeat (2) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("rst_out%0d", g), 32'(out_w[g]), 32'd1);
      check($sformatf("rst_done%0d", g), 32'(done_w[g]), 32'd0);
      check($sformatf("rst_busy%0d", g), 32'(busy_w[g]), 32'd0);
      check($sformatf("rst_ready%0d", g), 32'(ready_w[g]), 32'd0);
    end
    valid_w = '0;
    rst     = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) check($sformatf("post_rst_ready%0d", g), 32'(ready_w[g]), 32'd1);

    // 8N1, 4 clocks per bit
    send(0, 9'h0A5, 1'b0, "t1");
    check("t1_bits", obs_slice(0, 10), 32'h34A);
    idle(0, 3, "t1");

    // Parity even/odd
    send(1, 9'h0A5, 1'b0, "t2e");
    check("t2_par_even_a5", 32'(obs[9]), 32'd0);
    idle(1, 2, "t2e");
    send(2, 9'h0A5, 1'b0, "t2o");
    check("t2_par_odd_a5", 32'(obs[9]), 32'd1);
    idle(2, 2, "t2o");
    send(1, 9'h007, 1'b0, "t2e7");
    check("t2_par_even_07", 32'(obs[9]), 32'd1);
    idle(1, 2, "t2e7");

    // 7 data bits, 2 stop bits
    send(3, 9'h041, 1'b0, "t3");
    check("t3_data", obs_slice(1, 7), 32'h41);
    check("t3_stops", obs_slice(8, 2), 32'h3);
    idle(3, 2, "t3");

    // Back-to-back with valid held high
    send(0, 9'h055, 1'b1, "t4a");
    send(0, 9'h0AA, 1'b0, "t4b");
    idle(0, 2, "t4");

    // Reset during the third data bit
    build_frame(0, 9'h0C3);
    valid_w[0] = 1'b1;
    data_w[0]  = 9'h0C3;
    @(posedge clk);
    @(negedge clk);
    valid_w[0] = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("t5_pre_out%0d", k), 32'(out_w[0]), 32'(exp_bits[k / 4]));
    end
    rst        = 1'b1;
    valid_w[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_rst_out%0d", i), 32'(out_w[0]), 32'd1);
      check($sformatf("t5_rst_ready%0d", i), 32'(ready_w[0]), 32'd0);
      check($sformatf("t5_rst_done%0d", i), 32'(done_w[0]), 32'd0);
      check($sformatf("t5_rst_busy%0d", i), 32'(busy_w[0]), 32'd0);
    end
    rst        = 1'b0;
    valid_w[0] = 1'b0;
    idle(0, 4, "t5");
    send(0, 9'h03C, 1'b0, "t5f");
    idle(0, 2, "t5f");

    // One clock per bit
    send(4, 9'h0FF, 1'b0, "t6");
    check("t6_bits", obs_slice(0, 10), 32'h3FE);
    idle(4, 2, "t6");

    // Randomized frames on every configuration, some chained
    for (int g = 0; g < NCFG; g++) begin
      for (int r = 0; r < 6; r++) begin
        w     = 9'($urandom) & 9'((1 << cfg_db(g)) - 1);
        chain = (r < 5) && ($urandom_range(0, 1) == 1);
        send(g, w, chain, $sformatf("rnd_g%0d_r%0d", g, r));
        if (!chain) idle(g, $urandom_range(1, 3), $sformatf("rnd_g%0d_r%0d", g, r));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
